// File: rtl/dh_pkg.sv
// -----------------------------------------------------------------------------
// dh_pkg
// Purpose : Shared definitions for the Diffie-Hellman modular exponentiation
//           datapath and the partner controller that drives it.
// Contents: DH_LEN_DEFAULT - default operand width (prime, base, result)
//           dh_state_e     - exponentiator FSM encoding
// -----------------------------------------------------------------------------
package dh_pkg;

   localparam int DH_LEN_DEFAULT = 100;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_UPD  = 3'd2,
      ST_FIN  = 3'd3,
      ST_ERR  = 3'd4
   } dh_state_e;

endpackage : dh_pkg

// File: rtl/dh_modmul_serial.sv
// -----------------------------------------------------------------------------
// dh_modmul_serial
// Purpose : Bit-serial modular multiplier, prod = a*m mod p, MSB of m first.
//           One double-and-add step per clock; LEN steps per product.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           start         - pulse; the cycle it is high runs step 0
//           a, m, p       - operands (a, m < p), held stable for LEN cycles
//           prod          - product, valid the cycle after done
//           done          - high during the cycle that runs the final step
// -----------------------------------------------------------------------------
module dh_modmul_serial
   import dh_pkg::*;
#(
   parameter int LEN = DH_LEN_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [LEN-1:0] a,
   input  logic [LEN-1:0] m,
   input  logic [LEN-1:0] p,
   output logic [LEN-1:0] prod,
   output logic           done
);

   localparam int            CW        = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(LEN - 1);

   logic [LEN-1:0] acc_q, acc_d;
   logic [CW-1:0]  step_q, step_d;
   logic           run_q, run_d;

   logic           active;
   logic [CW-1:0]  step;
   logic [LEN-1:0] acc_in;
   logic [LEN:0]   p_ext;
   logic [LEN:0]   t_dbl, t_red, t_add, t_out;

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // can leave one unassigned and infer a latch.
      acc_d  = acc_q;
      step_d = step_q;
      run_d  = run_q;
      done   = 1'b0;

      active = start | run_q;
      // A start restarts from step 0 with a cleared accumulator, even if a
      // previous product is still in flight.
      step   = start ? '0 : step_q;
      acc_in = start ? '0 : acc_q;
      p_ext  = {1'b0, p};

      // acc < p holds on entry, so 2*acc < 2p and acc + a < 2p: one
      // conditional subtract after each half-step restores acc < p.
      t_dbl = {acc_in, 1'b0};
      t_red = (t_dbl >= p_ext) ? (t_dbl - p_ext) : t_dbl;
      t_add = m[LAST_STEP - step] ? (t_red + {1'b0, a}) : t_red;
      t_out = (t_add >= p_ext) ? (t_add - p_ext) : t_add;

      if (active) begin
         acc_d  = t_out[LEN-1:0];
         step_d = step + 1'b1;
         done   = (step == LAST_STEP);
         run_d  = (step != LAST_STEP);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         acc_q  <= '0;
         step_q <= '0;
         run_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         step_q <= step_d;
         run_q  <= run_d;
      end
   end

   assign prod = acc_q;

endmodule : dh_modmul_serial

// File: rtl/dh_modexp_engine.sv
// -----------------------------------------------------------------------------
// dh_modexp_engine
// Purpose : Constant-time right-to-left square-and-multiply exponentiator,
//           result = base_in^exp_in mod prime_in. Every exponent bit costs
//           LEN multiply cycles plus one update cycle, whatever its value.
// Ports   : clk, rst   - clock, synchronous active-high reset
//           start      - one-cycle request, accepted only when idle
//           prime_in   - modulus p (LEN bits)
//           base_in    - base, must be < prime_in (LEN bits)
//           exp_in     - exponent / secret (EXP_LEN bits)
//           busy       - an operation is in progress
//           done       - one-cycle pulse, result/err valid
//           err        - with done: prime_in < 2 or base_in >= prime_in
//           result     - base^exp mod p, held until the next completion
// -----------------------------------------------------------------------------
module dh_modexp_engine
   import dh_pkg::*;
#(
   parameter int LEN     = DH_LEN_DEFAULT,
   parameter int EXP_LEN = LEN
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [LEN-1:0]     prime_in,
   input  logic [LEN-1:0]     base_in,
   input  logic [EXP_LEN-1:0] exp_in,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [LEN-1:0]     result
);

   localparam int            BW       = (EXP_LEN > 1) ? $clog2(EXP_LEN) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(EXP_LEN - 1);

   dh_state_e          state_q, state_d;
   logic [LEN-1:0]     p_q, p_d;
   logic [LEN-1:0]     r_q, r_d;
   logic [LEN-1:0]     b_q, b_d;
   logic [EXP_LEN-1:0] e_q, e_d;
   logic [BW-1:0]      bitcnt_q, bitcnt_d;
   logic               mul_start_q, mul_start_d;
   logic [LEN-1:0]     result_q, result_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic [LEN-1:0]     m1_prod, m2_prod;
   logic               m1_done, m2_done;
   logic               mul_done;
   logic               operands_bad;

   // m1 = r*b (multiply step), m2 = b*b (square step); both always run so
   // the exponent bit only selects which result is kept.
   dh_modmul_serial #(.LEN(LEN)) u_mul_rb (
      .clk   (clk),
      .rst   (rst),
      .start (mul_start_q),
      .a     (r_q),
      .m     (b_q),
      .p     (p_q),
      .prod  (m1_prod),
      .done  (m1_done)
   );

   dh_modmul_serial #(.LEN(LEN)) u_mul_bb (
      .clk   (clk),
      .rst   (rst),
      .start (mul_start_q),
      .a     (b_q),
      .m     (b_q),
      .p     (p_q),
      .prod  (m2_prod),
      .done  (m2_done)
   );

   assign mul_done     = m1_done & m2_done;
   assign operands_bad = (prime_in < LEN'(2)) || (base_in >= prime_in);

   always_comb begin
      state_d     = state_q;
      p_d         = p_q;
      r_d         = r_q;
      b_d         = b_q;
      e_d         = e_q;
      bitcnt_d    = bitcnt_q;
      mul_start_d = 1'b0;
      result_d    = result_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // The cycle after an error report the FSM is already idle while
            // done is still high; a start there is dropped as well.
            if (start && !done_q) begin
               p_d = prime_in;
               if (operands_bad) begin
                  state_d = ST_ERR;
               end else begin
                  r_d         = LEN'(1);
                  b_d         = base_in;
                  e_d         = exp_in;
                  bitcnt_d    = '0;
                  mul_start_d = 1'b1;
                  state_d     = ST_MUL;
               end
            end
         end

         ST_MUL: begin
            if (mul_done) state_d = ST_UPD;
         end

         ST_UPD: begin
            if (e_q[0]) r_d = m1_prod;
            b_d      = m2_prod;
            e_d      = e_q >> 1;
            bitcnt_d = bitcnt_q + 1'b1;
            if (bitcnt_q == LAST_BIT) begin
               // Result and done are registered on the way into FIN so the
               // pulse coincides with the FIN cycle.
               result_d = e_q[0] ? m1_prod : r_q;
               done_d   = 1'b1;
               state_d  = ST_FIN;
            end else begin
               mul_start_d = 1'b1;
               state_d     = ST_MUL;
            end
         end

         ST_FIN: begin
            state_d = ST_IDLE;
         end

         ST_ERR: begin
            result_d = '0;
            done_d   = 1'b1;
            err_d    = 1'b1;
            state_d  = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         p_q         <= '0;
         r_q         <= '0;
         b_q         <= '0;
         e_q         <= '0;
         bitcnt_q    <= '0;
         mul_start_q <= 1'b0;
         result_q    <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         p_q         <= p_d;
         r_q         <= r_d;
         b_q         <= b_d;
         e_q         <= e_d;
         bitcnt_q    <= bitcnt_d;
         mul_start_q <= mul_start_d;
         result_q    <= result_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign busy   = (state_q != ST_IDLE);
   assign done   = done_q;
   assign err    = err_q;
   assign result = result_q;

endmodule : dh_modexp_engine

// File: tb/tb_dh_modexp_engine.sv
// -----------------------------------------------------------------------------
// tb_dh_modexp_engine
// Directed bench for dh_modexp_engine at LEN=8, EXP_LEN=8. Expected results
// are queued when a start is driven and popped when done appears.
// -----------------------------------------------------------------------------
module tb_dh_modexp_engine;

   localparam int LEN       = 8;
   localparam int EXP_LEN   = 8;
   localparam int LAT_OK    = EXP_LEN * (LEN + 1) + 1;
   localparam int LAT_ERR   = 2;
   localparam int TIMEOUT   = 200;

   typedef struct {
      logic [7:0] exp_res;
      logic       exp_err;
      int         exp_lat;
   } exp_t;

   logic               clk;
   logic               rst;
   logic               start;
   logic [LEN-1:0]     prime_in;
   logic [LEN-1:0]     base_in;
   logic [EXP_LEN-1:0] exp_in;
   logic               busy;
   logic               done;
   logic               err;
   logic [LEN-1:0]     result;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   aborted_done;

   dh_modexp_engine #(.LEN(LEN), .EXP_LEN(EXP_LEN)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .prime_in (prime_in),
      .base_in  (base_in),
      .exp_in   (exp_in),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .result   (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Drives one start (at a negedge, so it is sampled by the next posedge),
   // scrambles the operand inputs while running, optionally pokes start at
   // cycle poke_at and/or in the done cycle, then checks the popped entry.
   task automatic do_op(input string tag, input logic [7:0] p, input logic [7:0] b,
                        input logic [7:0] e, input logic [7:0] res, input logic er,
                        input int lat, input int poke_at, input bit poke_done);
      exp_t item;
      int   cyc     = 0;
      bit   seen    = 1'b0;
      bit   busy_ok = 1'b1;
      @(negedge clk);
      prime_in = p;
      base_in  = b;
      exp_in   = e;
      start    = 1'b1;
      sb.push_back('{exp_res: res, exp_err: er, exp_lat: lat});
      while (!seen && cyc < TIMEOUT) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) seen = 1'b1;
         else if (busy !== 1'b1) busy_ok = 1'b0;
         start    = 1'b0;
         prime_in = 8'($urandom);
         base_in  = 8'($urandom);
         exp_in   = 8'($urandom);
         if (cyc == poke_at || (seen && poke_done)) begin
            start    = 1'b1;
            prime_in = 8'd11;
            base_in  = 8'd2;
            exp_in   = 8'd7;
         end
      end
      item = sb.pop_front();
      check({tag, " done seen"}, 32'(seen), 32'd1);
      check({tag, " result"}, 32'(result), 32'(item.exp_res));
      check({tag, " err"}, 32'(err), 32'(item.exp_err));
      check({tag, " latency"}, 32'(cyc), 32'(item.exp_lat));
      check({tag, " busy while running"}, 32'(busy_ok), 32'd1);
      @(negedge clk);
      start = 1'b0;
      check({tag, " done one cycle"}, 32'(done), 32'd0);
      check({tag, " idle after done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      prime_in = '0;
      base_in  = '0;
      exp_in   = '0;
      repeat (3) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset err", 32'(err), 32'd0);
      check("reset result", 32'(result), 32'd0);
      rst = 1'b0;

      // Basic run; a second start at cycle 20 and one in the done cycle are ignored.
      do_op("p23 b5 e3", 8'd23, 8'd5, 8'd3, 8'd10, 1'b0, LAT_OK, 20, 1'b1);
      // Diffie-Hellman pair, public keys then shared keys.
      do_op("pub a e6", 8'd23, 8'd5, 8'd6, 8'd8, 1'b0, LAT_OK, 0, 1'b0);
      do_op("pub b e15", 8'd23, 8'd5, 8'd15, 8'd19, 1'b0, LAT_OK, 0, 1'b0);
      do_op("shared a", 8'd23, 8'd19, 8'd6, 8'd2, 1'b0, LAT_OK, 0, 1'b0);
      do_op("shared b", 8'd23, 8'd8, 8'd15, 8'd2, 1'b0, LAT_OK, 0, 1'b0);
      // Fixed latency regardless of exponent value.
      do_op("p11 b2 e10", 8'd11, 8'd2, 8'd10, 8'd1, 1'b0, LAT_OK, 0, 1'b0);
      do_op("exp zero", 8'd11, 8'd2, 8'd0, 8'd1, 1'b0, LAT_OK, 0, 1'b0);
      do_op("base zero", 8'd11, 8'd0, 8'd5, 8'd0, 1'b0, LAT_OK, 0, 1'b0);
      do_op("full exp", 8'd251, 8'd250, 8'd255, 8'd250, 1'b0, LAT_OK, 0, 1'b0);
      // Illegal operands; a start in the error done cycle is ignored.
      do_op("base>p", 8'd23, 8'd30, 8'd3, 8'd0, 1'b1, LAT_ERR, 0, 1'b1);
      do_op("base==p", 8'd23, 8'd23, 8'd3, 8'd0, 1'b1, LAT_ERR, 0, 1'b0);
      do_op("p=1", 8'd1, 8'd0, 8'd3, 8'd0, 1'b1, LAT_ERR, 0, 1'b0);
      do_op("p=0", 8'd0, 8'd0, 8'd3, 8'd0, 1'b1, LAT_ERR, 0, 1'b0);
      do_op("legal after err", 8'd23, 8'd5, 8'd3, 8'd10, 1'b0, LAT_OK, 0, 1'b0);

      // Reset at cycle 30 of a run aborts it without a done pulse.
      aborted_done = 1'b0;
      @(negedge clk);
      prime_in = 8'd23;
      base_in  = 8'd5;
      exp_in   = 8'd6;
      start    = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done === 1'b1) aborted_done = 1'b1;
         if (c == 30) rst = 1'b1;
      end
      @(negedge clk);
      check("abort busy", 32'(busy), 32'd0);
      check("abort result", 32'(result), 32'd0);
      check("abort done", 32'(done), 32'd0);
      rst = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (done === 1'b1) aborted_done = 1'b1;
      end
      check("no done after abort", 32'(aborted_done), 32'd0);
      do_op("fresh after abort", 8'd23, 8'd8, 8'd15, 8'd2, 1'b0, LAT_OK, 0, 1'b0);

      check("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule : tb_dh_modexp_engine
